// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, lock keymap and key mapping helper for the keypad scanner
package keypad_pkg;

    typedef enum logic [1:0] {IDLE, DRIVE, EVAL} scan_state_t;

    typedef enum logic [1:0] {NONE, SINGLE, MULTI} scan_result_t;

    // Key legends of the 4x4 lock keypad, indexed by row*4+col.
    localparam logic [3:0] LOCK_KEYMAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic [7:0] key_map(input logic [7:0] code, input int rows, input int cols);
        if (rows == 4 && cols == 4) begin
            return {4'h0, LOCK_KEYMAP[code[3:0]]};
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// rtl/keypad_col_sync.sv - two-flop synchroniser for the column sense lines, idles high
module keypad_col_sync #(
    parameter int COLS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [COLS-1:0] col_in,
    output logic [COLS-1:0] col_s
);

    logic [COLS-1:0] col_meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta <= '1;
            col_s    <= '1;
        end else begin
            col_meta <= col_in;
            col_s    <= col_meta;
        end
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// rtl/keypad_matrix_scanner.sv - R x C active-low keypad scanner with whole-scan debounce
// Optional auto-repeat is built when KEYPAD_REPEAT_EN is defined.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS               = 4,
    parameter int COLS               = 4,
    parameter int SETTLE_CYCLES      = 4,
    parameter int DEBOUNCE_SCANS     = 3,
    parameter int REPEAT_DELAY_SCANS = 64,
    parameter int REPEAT_RATE_SCANS  = 16,
    localparam int CW = $clog2(ROWS * COLS),
    localparam int VW = (CW < 4) ? 4 : CW
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [COLS-1:0] KEY_COL,
    output logic [ROWS-1:0] KEY_ROW,
    output logic [CW-1:0]   KEY_CODE,
    output logic [VW-1:0]   KEY_VALUE,
    output logic            KEY_VALID,
    output logic            KEY_RELEASE,
    output logic            KEY_HELD,
    output logic            KEY_MULTI,
    output logic            KEY_REPEAT
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

    scan_state_t              state, state_n;
    logic [RW-1:0]            row_idx, row_idx_n;
    logic [SW-1:0]            settle, settle_n;
    logic [COLS-1:0]          col_s;
    logic [ROWS-1:0][COLS-1:0] snap;

    scan_result_t             res_class, prev_class;
    logic [CW-1:0]            res_code, prev_code;
    logic [3:0]               cnt, cnt_n;
    logic                     same, stable, settle_last;

    logic [CW-1:0]            code_q;
    logic [VW-1:0]            value_q;
    logic                     valid_q, rel_q, held_q, multi_q, press_pend;
    logic                     rep_pend;

    keypad_col_sync #(.COLS(COLS)) u_col_sync (
        .clk    (CLK),
        .rst    (RST),
        .col_in (KEY_COL),
        .col_s  (col_s)
    );

    assign settle_last = (settle == SW'(SETTLE_CYCLES - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            row_idx <= '0;
            settle  <= '0;
        end else begin
            state   <= state_n;
            row_idx <= row_idx_n;
            settle  <= settle_n;
        end
    end

    always_comb begin
        state_n   = state;
        row_idx_n = row_idx;
        settle_n  = settle;
        case (state)
            IDLE: begin
                if (col_s != '1) begin
                    state_n   = DRIVE;
                    row_idx_n = '0;
                    settle_n  = '0;
                end
            end
            DRIVE: begin
                if (settle_last) begin
                    settle_n = '0;
                    if (row_idx == RW'(ROWS - 1)) state_n = EVAL;
                    else row_idx_n = row_idx + 1'b1;
                end else begin
                    settle_n = settle + 1'b1;
                end
            end
            EVAL: begin
                row_idx_n = '0;
                settle_n  = '0;
                // A stable empty matrix always leaves nothing held, so scanning can stop.
                state_n   = (stable && res_class == NONE) ? IDLE : DRIVE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Rows float high during EVAL so no key is powered while the snapshot is judged.
    always_comb begin
        KEY_ROW = '0;
        if (state == DRIVE) KEY_ROW = ~(ROWS'(1) << row_idx);
        else if (state == EVAL) KEY_ROW = '1;
    end

    always_comb begin
        int hits;
        hits     = 0;
        res_code = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (snap[r][c]) begin
                    hits     = hits + 1;
                    res_code = CW'(r * COLS + c);
                end
            end
        end
        if (hits == 0) res_class = NONE;
        else if (hits == 1) res_class = SINGLE;
        else res_class = MULTI;
    end

    always_comb begin
        same   = (res_class == prev_class) && (res_class != SINGLE || res_code == prev_code);
        cnt_n  = !same ? 4'd1 : ((cnt >= DEB) ? DEB : cnt + 4'd1);
        stable = (state == EVAL) && (cnt_n == DEB);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            snap       <= '0;
            prev_class <= NONE;
            prev_code  <= '0;
            cnt        <= '0;
            code_q     <= '0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            rel_q      <= 1'b0;
            held_q     <= 1'b0;
            multi_q    <= 1'b0;
            press_pend <= 1'b0;
        end else begin
            valid_q    <= press_pend | rep_pend;
            rel_q      <= 1'b0;
            press_pend <= 1'b0;
            if (press_pend) held_q <= 1'b1;
            if (state == DRIVE && settle_last) snap[row_idx] <= ~col_s;
            if (state == EVAL) begin
                cnt        <= cnt_n;
                prev_class <= res_class;
                prev_code  <= res_code;
                if (stable) begin
                    case (res_class)
                        NONE: begin
                            multi_q <= 1'b0;
                            if (held_q) begin
                                rel_q  <= 1'b1;
                                held_q <= 1'b0;
                            end
                        end
                        SINGLE: begin
                            multi_q <= 1'b0;
                            if (!held_q) begin
                                code_q     <= res_code;
                                value_q    <= VW'(key_map(8'(res_code), ROWS, COLS));
                                press_pend <= 1'b1;
                            end else if (res_code != code_q) begin
                                // Release now; the saturated count presses the new key next EVAL.
                                rel_q  <= 1'b1;
                                held_q <= 1'b0;
                            end
                        end
                        default: multi_q <= 1'b1;
                    endcase
                end
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY_SCANS > REPEAT_RATE_SCANS) ? REPEAT_DELAY_SCANS : REPEAT_RATE_SCANS;
    localparam int RPW  = $clog2(RMAX + 1);

    logic [RPW-1:0] rep_cnt, rep_nxt, rep_target;
    logic           rep_phase, rep_q;

    assign rep_nxt    = rep_cnt + 1'b1;
    assign rep_target = rep_phase ? RPW'(REPEAT_RATE_SCANS) : RPW'(REPEAT_DELAY_SCANS);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
            rep_pend  <= 1'b0;
            rep_q     <= 1'b0;
        end else begin
            rep_pend <= 1'b0;
            rep_q    <= rep_pend;
            if (stable) begin
                if (res_class == SINGLE && held_q && res_code == code_q) begin
                    if (rep_nxt == rep_target) begin
                        rep_pend  <= 1'b1;
                        rep_cnt   <= '0;
                        rep_phase <= 1'b1;
                    end else begin
                        rep_cnt <= rep_nxt;
                    end
                end else begin
                    rep_cnt   <= '0;
                    rep_phase <= 1'b0;
                end
            end
        end
    end

    assign KEY_REPEAT = rep_q;
`else
    logic repeat_params_unused;
    assign repeat_params_unused = REPEAT_DELAY_SCANS[0] ^ REPEAT_RATE_SCANS[0];
    assign rep_pend   = 1'b0;
    assign KEY_REPEAT = 1'b0;
`endif

    assign KEY_CODE    = code_q;
    assign KEY_VALUE   = value_q;
    assign KEY_VALID   = valid_q;
    assign KEY_RELEASE = rel_q;
    assign KEY_HELD    = held_q;
    assign KEY_MULTI   = multi_q;

endmodule
